// File: rtl/img_win_ctrl_pkg.sv
// ============================================================================
//  Module   : img_win_ctrl_pkg
//  Purpose  : Shared types and constants for the image-window controller:
//             window FSM encoding, default geometry/latency, display colours.
//  Options  : WIN_MIRROR_EN (consumed by img_win_ctrl / win_addr_gen)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package img_win_ctrl_pkg;

  // Window controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no window shown
    ST_ARMED  = 2'd1,  // config pending, waiting for frame start
    ST_ACTIVE = 2'd2   // window shown
  } win_state_t;

  // Default geometry and ROM latency
  localparam int DEF_H_DISP  = 1024;
  localparam int DEF_V_DISP  = 768;
  localparam int DEF_IMG_W   = 256;
  localparam int DEF_IMG_H   = 256;
  localparam int DEF_ROM_LAT = 2;

  // 24-bit RGB colours used by the display path around the window
  localparam logic [23:0] COL_BLACK  = 24'h00_00_00;
  localparam logic [23:0] COL_WHITE  = 24'hFF_FF_FF;
  localparam logic [23:0] COL_BG     = 24'h20_20_20;
  localparam logic [23:0] COL_BORDER = 24'h80_80_80;

  // Limit a 12-bit coordinate to an upper bound
  function automatic logic [11:0] clamp12(input logic [11:0] val,
                                          input logic [11:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/img_win_ctrl_win_addr_gen.sv
// ============================================================================
//  Module   : win_addr_gen
//  Purpose  : Combinational window hit test and ROM address arithmetic.
//  Options  : WIN_MIRROR_EN - horizontally mirrored column addressing
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module win_addr_gen #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic        active,
  input  logic        data_en,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic [11:0] win_x,
  input  logic [11:0] win_y,
  output logic        hit,
  output logic [15:0] addr
);

  logic [12:0] dx;
  logic [12:0] dy;
  logic [15:0] col;

  // Offsets into the window, hit compare and address (modulo 2^16)
  always_comb begin
    dx  = {1'b0, x_pos} - {1'b0, win_x};
    dy  = {1'b0, y_pos} - {1'b0, win_y};
    // Once x >= win_x holds, dx < IMG_W is the same as x < win_x + IMG_W
    hit = active && data_en &&
          (x_pos >= win_x) && (dx < 13'(IMG_W)) &&
          (y_pos >= win_y) && (dy < 13'(IMG_H));
`ifdef WIN_MIRROR_EN
    col = 16'(IMG_W - 1) - 16'(dx);
`else
    col = 16'(dx);
`endif
    addr = 16'(dy) * 16'(IMG_W) + col;
  end

endmodule

`default_nettype wire

// File: rtl/img_win_ctrl.sv
// ============================================================================
//  Module   : img_win_ctrl
//  Purpose  : Places a ROM image window on the active display. Accepts window
//             configuration via a valid/ready handshake, applies it at frame
//             start, issues ROM reads for window pixels and aligns the pixel
//             mux select with the ROM read latency.
//  Options  : WIN_MIRROR_EN - horizontally mirrored image addressing
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_win_ctrl
  import img_win_ctrl_pkg::*;
#(
  parameter int H_DISP  = DEF_H_DISP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        data_en,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic        cfg_valid,
  input  logic [11:0] cfg_x,
  input  logic [11:0] cfg_y,
  input  logic        cfg_en,
  output logic        cfg_ready,
  output logic        rom_en,
  output logic [15:0] rom_addr,
  output logic        sel_rom,
  output logic        frame_done
);

  localparam logic [11:0] X_MAX = 12'(H_DISP - IMG_W);
  localparam logic [11:0] Y_MAX = 12'(V_DISP - IMG_H);
`ifdef WIN_MIRROR_EN
  localparam logic [15:0] LAST_ADDR = 16'((IMG_H - 1) * IMG_W);
`else
  localparam logic [15:0] LAST_ADDR = 16'(IMG_W * IMG_H - 1);
`endif

  win_state_t  state;
  win_state_t  state_nxt;
  logic        frame_start;
  logic        cfg_acc;
  logic        arming;
  logic [11:0] pend_x;
  logic [11:0] pend_y;
  logic        pend_en;
  logic [11:0] win_x;
  logic [11:0] win_y;
  logic        eff_active;
  logic [11:0] eff_x;
  logic [11:0] eff_y;
  logic        hit;
  logic [15:0] addr_nxt;

  assign frame_start = data_en && (x_pos == 12'd0) && (y_pos == 12'd0);
  assign cfg_acc     = cfg_valid && cfg_ready;
  assign arming      = frame_start && (state == ST_ARMED);

  // The frame-start pixel already belongs to the new frame, so when a pending
  // window is applied it is also used for the hit test on that same pixel.
  assign eff_active = arming ? pend_en : (state == ST_ACTIVE);
  assign eff_x      = arming ? pend_x  : win_x;
  assign eff_y      = arming ? pend_y  : win_y;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake ready; ARMED blocks a second pending request
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b1;
    case (state)
      ST_IDLE:   if (cfg_acc) state_nxt = ST_ARMED;
      ST_ARMED: begin
        cfg_ready = 1'b0;
        if (frame_start) state_nxt = pend_en ? ST_ACTIVE : ST_IDLE;
      end
      ST_ACTIVE: if (cfg_acc) state_nxt = ST_ARMED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Pending window captured (clamped) on accept, copied to live at frame start
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pend_x  <= '0;
      pend_y  <= '0;
      pend_en <= 1'b0;
      win_x   <= '0;
      win_y   <= '0;
    end else begin
      if (cfg_acc) begin
        pend_x  <= clamp12(cfg_x, X_MAX);
        pend_y  <= clamp12(cfg_y, Y_MAX);
        pend_en <= cfg_en;
      end
      if (arming) begin
        win_x <= pend_x;
        win_y <= pend_y;
      end
    end
  end

  win_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_addr_gen (
    .active  (eff_active),
    .data_en (data_en),
    .x_pos   (x_pos),
    .y_pos   (y_pos),
    .win_x   (eff_x),
    .win_y   (eff_y),
    .hit     (hit),
    .addr    (addr_nxt)
  );

  // ROM read strobe/address (address holds between hits) and end-of-image pulse
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      rom_en     <= hit;
      if (hit) rom_addr <= addr_nxt;
      frame_done <= rom_en && (rom_addr == LAST_ADDR);
    end
  end

  // Delay rom_en by the ROM latency to produce the mux select
  generate
    if (ROM_LAT == 0) begin : g_lat_none
      assign sel_rom = rom_en;
    end else if (ROM_LAT == 1) begin : g_lat_one
      logic lat_q;
      // Single-stage select delay
      always_ff @(posedge clk_in) begin
        if (rst) lat_q <= 1'b0;
        else     lat_q <= rom_en;
      end
      assign sel_rom = lat_q;
    end else begin : g_lat_multi
      logic [ROM_LAT-1:0] lat_pipe;
      // Multi-stage select delay, flushed by reset
      always_ff @(posedge clk_in) begin
        if (rst) lat_pipe <= '0;
        else     lat_pipe <= {lat_pipe[ROM_LAT-2:0], rom_en};
      end
      assign sel_rom = lat_pipe[ROM_LAT-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_img_win_ctrl.sv
// ============================================================================
//  Module   : tb_img_win_ctrl
//  Purpose  : Self-checking bench for img_win_ctrl using a reduced display
//             geometry, a behavioural reference model and randomized configs.
//  Options  : WIN_MIRROR_EN - expected addressing follows the mirrored image
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_win_ctrl;

  localparam int H    = 64;
  localparam int V    = 48;
  localparam int IW   = 16;
  localparam int IH   = 16;
  localparam int LAT  = 2;
  localparam int NPIX = IW * IH;
  localparam int XMAX = H - IW;
  localparam int YMAX = V - IH;
`ifdef WIN_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif
  localparam int LAST = MIRROR ? (IH - 1) * IW : NPIX - 1;

  localparam int MI = 0;  // idle
  localparam int MA = 1;  // armed
  localparam int MV = 2;  // active

  logic        clk = 1'b0;
  logic        rst;
  logic        data_en;
  logic [11:0] x_pos, y_pos;
  logic        cfg_valid;
  logic [11:0] cfg_x, cfg_y;
  logic        cfg_en;
  logic        cfg_ready;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic        sel_rom;
  logic        frame_done;

  always #5 clk = ~clk;

  img_win_ctrl #(
    .H_DISP  (H),
    .V_DISP  (V),
    .IMG_W   (IW),
    .IMG_H   (IH),
    .ROM_LAT (LAT)
  ) dut (
    .clk_in     (clk),
    .rst        (rst),
    .data_en    (data_en),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .cfg_valid  (cfg_valid),
    .cfg_x      (cfg_x),
    .cfg_y      (cfg_y),
    .cfg_en     (cfg_en),
    .cfg_ready  (cfg_ready),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .sel_rom    (sel_rom),
    .frame_done (frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode = MI;
  int m_px = 0, m_py = 0, m_wx = 0, m_wy = 0;
  bit m_pen = 0;
  bit m_rom_en = 0;
  int m_addr = 0;
  bit m_fd = 0;
  bit m_hist [0:LAT];   // m_hist[k] = rom_en as it was k clocks ago

  always @(posedge clk) begin : ref_model
    bit fs, acc, hitp, fd_next;
    int dx, dy;
    if (rst) begin
      m_mode = MI; m_px = 0; m_py = 0; m_pen = 0; m_wx = 0; m_wy = 0;
      m_rom_en = 0; m_addr = 0; m_fd = 0;
      for (int i = 0; i <= LAT; i++) m_hist[i] = 0;
    end else begin
      fs      = data_en && x_pos == 0 && y_pos == 0;
      acc     = cfg_valid && (m_mode != MA);
      fd_next = m_rom_en && (m_addr == LAST);
      if (fs && m_mode == MA) begin
        m_wx = m_px; m_wy = m_py;
        m_mode = m_pen ? MV : MI;
      end
      dx   = int'(x_pos) - m_wx;
      dy   = int'(y_pos) - m_wy;
      hitp = (m_mode == MV) && data_en && dx >= 0 && dx < IW && dy >= 0 && dy < IH;
      if (hitp) m_addr = (dy * IW + (MIRROR ? (IW - 1 - dx) : dx)) % 65536;
      m_rom_en = hitp;
      for (int i = LAT; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = hitp;
      if (acc) begin
        m_px   = (int'(cfg_x) > XMAX) ? XMAX : int'(cfg_x);
        m_py   = (int'(cfg_y) > YMAX) ? YMAX : int'(cfg_y);
        m_pen  = cfg_en;
        m_mode = MA;
      end
      m_fd = fd_next;
    end
  end

  // ---------------- per-frame statistics from DUT outputs ----------------
  int cyc = 0;
  int st_cnt, st_fd, st_order_err, st_en_cyc, st_sel_cyc;
  int st_first_x, st_first_y, st_first_addr, st_last_x, st_last_y, st_last_addr;

  function automatic int exp_seq(input int k);
    return MIRROR ? ((k / IW) * IW + IW - 1 - (k % IW)) : k;
  endfunction

  task automatic clear_stats();
    st_cnt = 0; st_fd = 0; st_order_err = 0; st_en_cyc = -1; st_sel_cyc = -1;
    st_first_x = -1; st_first_y = -1; st_first_addr = -1;
    st_last_x = -1; st_last_y = -1; st_last_addr = -1;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check("cfg_ready",  cfg_ready,  m_mode != MA);
    check("rom_en",     rom_en,     m_rom_en);
    check("rom_addr",   rom_addr,   m_addr);
    check("sel_rom",    sel_rom,    m_hist[LAT]);
    check("frame_done", frame_done, m_fd);
    if (rom_en) begin
      if (st_cnt == 0) begin
        st_first_x = x_pos; st_first_y = y_pos; st_first_addr = rom_addr; st_en_cyc = cyc;
      end
      if (int'(rom_addr) != exp_seq(st_cnt)) st_order_err++;
      st_last_x = x_pos; st_last_y = y_pos; st_last_addr = rom_addr;
      st_cnt++;
    end
    if (sel_rom && st_sel_cyc < 0) st_sel_cyc = cyc;
    if (frame_done) st_fd++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pix(input int x, input int y, input bit de);
    x_pos = 12'(x); y_pos = 12'(y); data_en = de;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic blank(input int n);
    repeat (n) pix($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0);
  endtask

  task automatic set_cfg(input int cx, input int cy, input bit cen);
    cfg_valid = 1'b1; cfg_x = 12'(cx); cfg_y = 12'(cy); cfg_en = cen;
  endtask

  // Raster one frame; optional config at pixel cfg_idx, optional reset at rst_idx
  task automatic frame(input int cfg_idx, input int cx, input int cy, input bit cen,
                       input int rst_idx, input bit gaps);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        int idx;
        idx = y * H + x;
        if (idx == cfg_idx) set_cfg(cx, cy, cen);
        if (idx == rst_idx) begin
          rst = 1'b1;
          pix(x, y, 1'b1);
          rst = 1'b0;
          return;
        end
        pix(x, y, 1'b1);
      end
      if (gaps) blank($urandom_range(0, 3));
    end
    blank(4);
  endtask

  initial begin
    bit saw;
    rst = 1'b1; data_en = 1'b0; x_pos = '0; y_pos = '0;
    cfg_valid = 1'b0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
    clear_stats();

    // Reset state
    blank(3);
    check("rst_rom_en",    rom_en,     0);
    check("rst_rom_addr",  rom_addr,   0);
    check("rst_sel_rom",   sel_rom,    0);
    check("rst_frame_done", frame_done, 0);
    check("rst_cfg_ready", cfg_ready,  1);
    rst = 1'b0;
    blank(2);

    // First window: origin (20,10)
    set_cfg(20, 10, 1'b1);
    blank(1);
    check("s1_ready_armed", cfg_ready, 0);
    clear_stats();
    frame(-1, 0, 0, 1'b0, -1, 1'b1);
    check("s1_first_x",    st_first_x,    20);
    check("s1_first_y",    st_first_y,    10);
    check("s1_first_addr", st_first_addr, exp_seq(0));
    check("s1_sel_delay",  st_sel_cyc - st_en_cyc, LAT);
    check("s1_count",      st_cnt,        NPIX);
    check("s1_done",       st_fd,         1);

    // Full image at origin (0,0)
    set_cfg(0, 0, 1'b1);
    blank(1);
    clear_stats();
    frame(-1, 0, 0, 1'b0, -1, 1'b1);
    check("s2_count",     st_cnt,       NPIX);
    check("s2_order",     st_order_err, 0);
    check("s2_last_addr", st_last_addr, exp_seq(NPIX - 1));
    check("s2_done",      st_fd,        1);

    // Config accepted mid-frame (below the window), window disabled
    clear_stats();
    frame(20 * H, 5, 5, 1'b0, -1, 1'b1);
    check("s4_count_same", st_cnt, NPIX);
    check("s4_ready_low",  cfg_ready, 0);
    clear_stats();
    frame(-1, 0, 0, 1'b0, -1, 1'b1);
    check("s4_count_off",  st_cnt, 0);
    check("s4_done_off",   st_fd, 0);
    check("s4_ready_high", cfg_ready, 1);

    // Origin clamping
    set_cfg(1000, 700, 1'b1);
    blank(1);
    clear_stats();
    frame(-1, 0, 0, 1'b0, -1, 1'b1);
    check("s3_first_x",   st_first_x,   XMAX);
    check("s3_first_y",   st_first_y,   YMAX);
    check("s3_last_x",    st_last_x,    H - 1);
    check("s3_last_y",    st_last_y,    V - 1);
    check("s3_last_addr", st_last_addr, exp_seq(NPIX - 1));
    check("s3_count",     st_cnt,       NPIX);

    // Reset in the middle of a window row
    set_cfg(0, 0, 1'b1);
    blank(1);
    frame(-1, 0, 0, 1'b0, 3 * H + 5, 1'b0);
    check("s5_rom_en",     rom_en,     0);
    check("s5_sel_rom",    sel_rom,    0);
    check("s5_frame_done", frame_done, 0);
    check("s5_cfg_ready",  cfg_ready,  1);
    saw = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      pix(6 + k, 3, 1'b1);
      if (sel_rom) saw = 1'b1;
    end
    check("s5_no_stale_sel", saw, 0);
    blank(3);

    // Randomized configs; the first lands exactly on a frame start pixel
    for (int r = 0; r < 4; r++) begin
      int ci;
      if ($urandom_range(0, 1) == 1)
        set_cfg($urandom_range(0, 80), $urandom_range(0, 60), $urandom_range(0, 3) != 0);
      blank(1);
      ci = (r == 0) ? 0 : (($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, H * V - 1));
      frame(ci, $urandom_range(0, 80), $urandom_range(0, 60),
            $urandom_range(0, 3) != 0, -1, 1'b1);
    end
    frame(-1, 0, 0, 1'b0, -1, 1'b1);
    blank(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/img_win_ctrl.md
IMG_WIN_CTRL -- requirements
Module: img_win_ctrl

Interface
REQ-001 Parameter H_DISP, default 1024: active display width in pixels.
REQ-002 Parameter V_DISP, default 768: active display height in lines.
REQ-003 Parameter IMG_W, default 256: ROM image width in pixels.
REQ-004 Parameter IMG_H, default 256: ROM image height in lines.
REQ-005 Parameter ROM_LAT, default 2: image ROM read latency in clocks.
REQ-006 clk_in  input  1: pixel clock; the block's only clock.
REQ-007 rst  input  1: reset, synchronous, active-high.
REQ-008 data_en  input  1: active-video qualifier from the timing generator.
REQ-009 x_pos, y_pos  input  12 each: current active pixel coordinates.
REQ-010 cfg_valid  input  1: window configuration request.
REQ-011 cfg_x, cfg_y  input  12 each: requested window origin.
REQ-012 cfg_en  input  1: window enable carried with the request.
REQ-013 cfg_ready  output  1: a request is accepted on cycles where both cfg_valid and cfg_ready are high.
REQ-014 rom_en  output  1: ROM read strobe.
REQ-015 rom_addr  output  16: ROM read address.
REQ-016 sel_rom  output  1: pixel-mux select, aligned with ROM data.
REQ-017 frame_done  output  1: one-cycle pulse after the last window pixel is read.

Function
REQ-018 Frame start occurs when data_en=1, x_pos=0 and y_pos=0.
REQ-019 FSM states: IDLE (no window), ARMED (pending config, waiting for frame start), ACTIVE (window shown).
REQ-020 Transitions:
- IDLE->ARMED on config accept.
- ARMED->ACTIVE at frame start if pending cfg_en=1, else ARMED->IDLE.
- ACTIVE->ARMED on config accept.
REQ-021 cfg_ready is 1 in IDLE and ACTIVE and 0 in ARMED, so at most one request is pending.
REQ-022 At frame start, pending values are copied into the live window registers; the live window never changes mid-frame.
REQ-023 Origin clamping at accept:
- cfg_x > H_DISP-IMG_W is stored as H_DISP-IMG_W.
- cfg_y > V_DISP-IMG_H is stored as V_DISP-IMG_H.
REQ-024 A pixel hits the window when state=ACTIVE, data_en=1, win_x <= x_pos < win_x+IMG_W and win_y <= y_pos < win_y+IMG_H.
REQ-025 One cycle after a hit: rom_en=1 and rom_addr=(y_pos-win_y)*IMG_W+(x_pos-win_x), truncated to 16 bits.
- On non-hit cycles: rom_en=0 and rom_addr holds its value.
REQ-026 sel_rom equals rom_en delayed by ROM_LAT clocks, so total latency from hit to sel_rom is 1+ROM_LAT.
REQ-027 frame_done pulses one cycle after rom_en=1 with rom_addr=IMG_W*IMG_H-1.
REQ-028 A config accepted in the same cycle as frame start does not apply to that frame; it applies at the next frame start.
REQ-029 Frame start while ACTIVE with nothing pending keeps the current window.

Reset
REQ-030 While rst=1 at a clock edge:
- state=IDLE; rom_en, sel_rom, frame_done and the internal delay line = 0; rom_addr=0; cfg_ready=1.
- Live and pending window registers = 0.
REQ-031 Reset mid-frame takes effect at the next edge; the sel_rom pipeline is flushed and no stale sel_rom pulse follows.

Configuration
REQ-032 With macro WIN_MIRROR_EN defined, the address column term is (IMG_W-1)-(x_pos-win_x), giving a horizontally mirrored image; frame_done then triggers on the last issued address (row IMG_H-1, column 0).
REQ-033 Without WIN_MIRROR_EN, addressing follows REQ-025 exactly and no mirror logic is present.

Structure
REQ-034 A shared package holds:
- the FSM state encoding (IDLE/ARMED/ACTIVE);
- the defaults H_DISP, V_DISP, IMG_W, IMG_H, ROM_LAT;
- the 24-bit colour constants used by the display path.
REQ-035 Sub-module win_addr_gen holds the hit compare and address arithmetic; the FSM, config handshake and latency pipeline stay in img_win_ctrl.

Verification
REQ-036 Reset, then cfg (x=100, y=50, en=1) accepted, then frame start -> first rom_en at x=100, y=50 with rom_addr=0; sel_rom=1 exactly 3 clocks after that hit.
REQ-037 Full frame with origin (0,0) -> exactly 65536 rom_en pulses, addresses 0..65535 in order, one frame_done pulse.
REQ-038 cfg x=1000, y=700 -> stored origin (768,512); last hit at x=1023, y=767 gives rom_addr=65535.
REQ-039 cfg accepted mid-frame -> cfg_ready=0 until next frame start, current window unchanged; cfg with en=0 -> no rom_en in the following frame.
REQ-040 rst=1 asserted during a window row -> rom_en, sel_rom, frame_done are 0 from the next edge; cfg_ready=1.
REQ-041 With WIN_MIRROR_EN and origin (0,0), the hit at x=0, y=0 -> rom_addr=255; the hit at x=255, y=0 -> rom_addr=0.
